// File: rtl/dmem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : dmem_arbiter_if
// Description : Requester and SRAM-side signal bundle for the data-memory arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_arbiter_if #(
    parameter int AW = 16
);
    logic          m0_req;
    logic [AW-1:0] m0_a;
    logic [3:0]    m0_we;
    logic [31:0]   m0_wd;
    logic [3:0]    m0_re;
    logic          m0_gnt;
    logic [31:0]   m0_rd;
    logic          m0_rvld;

    logic          m1_req;
    logic [AW-1:0] m1_a;
    logic [3:0]    m1_we;
    logic [31:0]   m1_wd;
    logic [3:0]    m1_re;
    logic          m1_gnt;
    logic [31:0]   m1_rd;
    logic          m1_rvld;

    logic [AW-3:0] sram_a;
    logic [3:0]    sram_we;
    logic [31:0]   sram_wd;
    logic [3:0]    sram_re;
    logic [31:0]   sram_rd;

    modport slave (
        input  m0_req, m0_a, m0_we, m0_wd, m0_re,
        output m0_gnt, m0_rd, m0_rvld,
        input  m1_req, m1_a, m1_we, m1_wd, m1_re,
        output m1_gnt, m1_rd, m1_rvld,
        output sram_a, sram_we, sram_wd, sram_re,
        input  sram_rd
    );

    modport master (
        output m0_req, m0_a, m0_we, m0_wd, m0_re,
        input  m0_gnt, m0_rd, m0_rvld,
        output m1_req, m1_a, m1_we, m1_wd, m1_re,
        input  m1_gnt, m1_rd, m1_rvld,
        input  sram_a, sram_we, sram_wd, sram_re,
        output sram_rd
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : dmem_arbiter
// Description : Two-port arbiter for the single-port data SRAM; port 0 has
//               priority, port 1 is force-granted after MAX_WAIT denials.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
    parameter int AW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCE1 = 1'b1
    } state_t;

    state_t        r_state;
    logic [3:0]    r_wait_cnt;

    logic [AW-3:0] r_sram_a;
    logic [3:0]    r_sram_we;
    logic [31:0]   r_sram_wd;
    logic [3:0]    r_sram_re;

    logic          r_p1_vld;
    logic          r_p1_own;
    logic [3:0]    r_p1_re;
    logic          r_p2_vld;
    logic          r_p2_own;
    logic [3:0]    r_p2_re;

    logic [31:0]   r_m0_rd;
    logic          r_m0_rvld;
    logic [31:0]   r_m1_rd;
    logic          r_m1_rvld;

    logic          w_m0_gnt;
    logic          w_m1_gnt;
    logic          w_acc;
    logic [AW-3:0] w_a;
    logic [3:0]    w_we;
    logic [31:0]   w_wd;
    logic [3:0]    w_re;
    logic [3:0]    w_re_eff;
    logic [3:0]    w_wait_nxt;
    logic [31:0]   w_rd_mask;
    logic [31:0]   w_rd_masked;
    logic          w_unused_lsb;

    // Port 1 only loses to port 0 while the arbiter is not in the forced state.
    assign w_m0_gnt = ~rst & bus.m0_req & (r_state == ST_NORMAL);
    assign w_m1_gnt = ~rst & bus.m1_req & ((r_state == ST_FORCE1) | ~bus.m0_req);
    assign w_acc    = w_m0_gnt | w_m1_gnt;

    assign w_a      = w_m1_gnt ? bus.m1_a[AW-1:2] : bus.m0_a[AW-1:2];
    assign w_we     = w_m1_gnt ? bus.m1_we : bus.m0_we;
    assign w_wd     = w_m1_gnt ? bus.m1_wd : bus.m0_wd;
    assign w_re     = w_m1_gnt ? bus.m1_re : bus.m0_re;
    assign w_re_eff = (w_we != 4'h0) ? 4'h0 : w_re;

    assign w_unused_lsb = ^{bus.m0_a[1:0], bus.m1_a[1:0]};

    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (!bus.m1_req || w_m1_gnt) begin
            w_wait_nxt = 4'd0;
        end else if (r_wait_cnt < C_MAX_WAIT) begin
            w_wait_nxt = r_wait_cnt + 4'd1;
        end
    end

    assign w_rd_mask   = {{8{r_p2_re[3]}}, {8{r_p2_re[2]}}, {8{r_p2_re[1]}}, {8{r_p2_re[0]}}};
    assign w_rd_masked = bus.sram_rd & w_rd_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_NORMAL;
            r_wait_cnt <= 4'd0;
            r_sram_a   <= '0;
            r_sram_we  <= 4'h0;
            r_sram_wd  <= 32'h0;
            r_sram_re  <= 4'h0;
            r_p1_vld   <= 1'b0;
            r_p1_own   <= 1'b0;
            r_p1_re    <= 4'h0;
            r_p2_vld   <= 1'b0;
            r_p2_own   <= 1'b0;
            r_p2_re    <= 4'h0;
            r_m0_rd    <= 32'h0;
            r_m0_rvld  <= 1'b0;
            r_m1_rd    <= 32'h0;
            r_m1_rvld  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_nxt;

            case (r_state)
                ST_NORMAL: if (w_wait_nxt == C_MAX_WAIT) r_state <= ST_FORCE1;
                ST_FORCE1: if (!bus.m1_req || w_m1_gnt) r_state <= ST_NORMAL;
                default:   r_state <= ST_NORMAL;
            endcase

            // Address and write data hold when idle; only the enables drop.
            if (w_acc) begin
                r_sram_a  <= w_a;
                r_sram_wd <= w_wd;
                r_sram_we <= w_we;
                r_sram_re <= w_re_eff;
            end else begin
                r_sram_we <= 4'h0;
                r_sram_re <= 4'h0;
            end

            r_p1_vld <= w_acc & (w_re_eff != 4'h0);
            r_p1_own <= w_m1_gnt;
            r_p1_re  <= w_re_eff;
            r_p2_vld <= r_p1_vld;
            r_p2_own <= r_p1_own;
            r_p2_re  <= r_p1_re;

            r_m0_rvld <= r_p2_vld & ~r_p2_own;
            r_m1_rvld <= r_p2_vld & r_p2_own;
            if (r_p2_vld && !r_p2_own) r_m0_rd <= w_rd_masked;
            if (r_p2_vld &&  r_p2_own) r_m1_rd <= w_rd_masked;
        end
    end

    assign bus.m0_gnt  = w_m0_gnt;
    assign bus.m1_gnt  = w_m1_gnt;
    assign bus.m0_rd   = r_m0_rd;
    assign bus.m0_rvld = r_m0_rvld;
    assign bus.m1_rd   = r_m1_rd;
    assign bus.m1_rvld = r_m1_rvld;
    assign bus.sram_a  = r_sram_a;
    assign bus.sram_we = r_sram_we;
    assign bus.sram_wd = r_sram_wd;
    assign bus.sram_re = r_sram_re;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with an SRAM model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;
    localparam int AW       = 16;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW)) bus ();

    dmem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Single-port SRAM with one-cycle registered read.
    logic [31:0] sram_mem [0:(1<<(AW-2))-1];
    logic [31:0] sram_rd_r = 32'h0;
    assign bus.sram_rd = sram_rd_r;
    initial for (int i = 0; i < (1<<(AW-2)); i++) sram_mem[i] = 32'h0;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.sram_we[b]) sram_mem[bus.sram_a][8*b +: 8] <= bus.sram_wd[8*b +: 8];
        if (|bus.sram_re) sram_rd_r <= sram_mem[bus.sram_a];
    end

    typedef struct packed {
        logic        rst;
        logic        req0;
        logic [15:0] a0;
        logic [3:0]  we0;
        logic [31:0] wd0;
        logic [3:0]  re0;
        logic        req1;
        logic [15:0] a1;
        logic [3:0]  we1;
        logic [31:0] wd1;
        logic [3:0]  re1;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        g0;
        logic        g1;
        logic [13:0] sa;
        logic [3:0]  swe;
        logic [3:0]  sre;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
    } vec_t;

    typedef struct {
        int          due;
        logic        port;
        logic [31:0] data;
    } resp_t;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int          cur = 0;
    int          m_wait = 0;
    logic [31:0] mmem [int];
    resp_t       rq [$];
    logic [13:0] ex_sa;
    logic [31:0] ex_swd;
    logic [3:0]  ex_swe, ex_sre;
    logic        ex_v0, ex_v1;
    logic [31:0] ex_d0, ex_d1;
    logic        eg0, eg1, dg0, dg1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] e);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{e[b]}};
        return m;
    endfunction

    function automatic logic [31:0] mrd(input int w);
        return mmem.exists(w) ? mmem[w] : 32'h0;
    endfunction

    function automatic stim_t st_idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t st0(input logic [15:0] a, input logic [3:0] we,
                                  input logic [31:0] wd, input logic [3:0] re);
        stim_t s = '0;
        s.req0 = 1'b1; s.a0 = a; s.we0 = we; s.wd0 = wd; s.re0 = re;
        return s;
    endfunction

    function automatic stim_t st1(input logic [15:0] a, input logic [3:0] we,
                                  input logic [31:0] wd, input logic [3:0] re);
        stim_t s = '0;
        s.req1 = 1'b1; s.a1 = a; s.we1 = we; s.wd1 = wd; s.re1 = re;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic g0, input logic g1,
                                 input logic [13:0] sa, input logic [3:0] swe, input logic [3:0] sre,
                                 input logic v0, input logic [31:0] d0,
                                 input logic v1, input logic [31:0] d1);
        vec_t v;
        v.s = s; v.g0 = g0; v.g1 = g1; v.sa = sa; v.swe = swe; v.sre = sre;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        return v;
    endfunction

    // One clock cycle: drive, check grants, predict, clock, check registered outputs.
    task automatic step(input stim_t s);
        logic        force1;
        logic [15:0] a;
        logic [3:0]  we, re;
        logic [31:0] wd, old;
        int          w;
        rst = s.rst;
        bus.m0_req = s.req0; bus.m0_a = s.a0; bus.m0_we = s.we0; bus.m0_wd = s.wd0; bus.m0_re = s.re0;
        bus.m1_req = s.req1; bus.m1_a = s.a1; bus.m1_we = s.we1; bus.m1_wd = s.wd1; bus.m1_re = s.re1;
        #2;
        force1 = (m_wait >= MAX_WAIT);
        eg0 = !s.rst && s.req0 && !force1;
        eg1 = !s.rst && s.req1 && (force1 || !s.req0);
        dg0 = bus.m0_gnt;
        dg1 = bus.m1_gnt;
        chk("m0_gnt", 32'(dg0), 32'(eg0));
        chk("m1_gnt", 32'(dg1), 32'(eg1));
        if (s.rst || !s.req1 || eg1) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
        if (eg0 || eg1) begin
            a  = eg1 ? s.a1  : s.a0;
            we = eg1 ? s.we1 : s.we0;
            wd = eg1 ? s.wd1 : s.wd0;
            re = eg1 ? s.re1 : s.re0;
            w  = int'(a[15:2]);
            if (we != 4'h0) begin
                old = mrd(w);
                for (int b = 0; b < 4; b++) if (we[b]) old[8*b +: 8] = wd[8*b +: 8];
                mmem[w] = old;
            end
            ex_sa  = a[15:2];
            ex_swd = wd;
            ex_swe = we;
            ex_sre = (we != 4'h0) ? 4'h0 : re;
            if (we == 4'h0 && re != 4'h0)
                rq.push_back('{due: cur + 3, port: eg1, data: mrd(w) & bmask(re)});
        end else begin
            ex_swe = 4'h0;
            ex_sre = 4'h0;
        end
        @(posedge clk);
        cur++;
        #1;
        if (s.rst) begin
            rq.delete();
            m_wait = 0;
            ex_sa = '0; ex_swd = '0; ex_swe = '0; ex_sre = '0;
            ex_v0 = 1'b0; ex_v1 = 1'b0; ex_d0 = '0; ex_d1 = '0;
        end else begin
            ex_v0 = 1'b0;
            ex_v1 = 1'b0;
            for (int i = rq.size() - 1; i >= 0; i--) begin
                if (rq[i].due == cur) begin
                    if (rq[i].port) begin ex_v1 = 1'b1; ex_d1 = rq[i].data; end
                    else            begin ex_v0 = 1'b1; ex_d0 = rq[i].data; end
                    rq.delete(i);
                end
            end
        end
        chk("sram_a",  32'(bus.sram_a),  32'(ex_sa));
        chk("sram_we", 32'(bus.sram_we), 32'(ex_swe));
        chk("sram_wd", bus.sram_wd, ex_swd);
        chk("sram_re", 32'(bus.sram_re), 32'(ex_sre));
        chk("m0_rvld", 32'(bus.m0_rvld), 32'(ex_v0));
        chk("m0_rd",   bus.m0_rd, ex_d0);
        chk("m1_rvld", 32'(bus.m1_rvld), 32'(ex_v1));
        chk("m1_rd",   bus.m1_rd, ex_d1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl [13];
        stim_t s;
        stim_t p0, p1;
        logic  pend0, pend1;

        tbl[0]  = mkv(st0(16'h0010, 4'hF, 32'hDEADBEEF, 4'h0), 1, 0, 14'h004, 4'hF, 4'h0, 0, 32'h0,        0, 32'h0);
        tbl[1]  = mkv(st1(16'h0020, 4'hF, 32'hCAFE0008, 4'h0), 0, 1, 14'h008, 4'hF, 4'h0, 0, 32'h0,        0, 32'h0);
        tbl[2]  = mkv(st0(16'h0030, 4'hF, 32'h0BAD000C, 4'h0), 1, 0, 14'h00C, 4'hF, 4'h0, 0, 32'h0,        0, 32'h0);
        tbl[3]  = mkv(st0(16'h0010, 4'h0, 32'h0,        4'hF), 1, 0, 14'h004, 4'h0, 4'hF, 0, 32'h0,        0, 32'h0);
        tbl[4]  = mkv(st0(16'h0010, 4'h0, 32'h0,        4'h4), 1, 0, 14'h004, 4'h0, 4'h4, 0, 32'h0,        0, 32'h0);
        tbl[5]  = mkv(st1(16'h0020, 4'h0, 32'h0,        4'hF), 0, 1, 14'h008, 4'h0, 4'hF, 1, 32'hDEADBEEF, 0, 32'h0);
        tbl[6]  = mkv(st0(16'h0030, 4'h0, 32'h0,        4'hF), 1, 0, 14'h00C, 4'h0, 4'hF, 1, 32'h00AD0000, 0, 32'h0);
        tbl[7]  = mkv(st0(16'h0010, 4'h1, 32'h11223344, 4'hF), 1, 0, 14'h004, 4'h1, 4'h0, 0, 32'h00AD0000, 1, 32'hCAFE0008);
        tbl[8]  = mkv(st_idle(),                               0, 0, 14'h004, 4'h0, 4'h0, 1, 32'h0BAD000C, 0, 32'hCAFE0008);
        tbl[9]  = mkv(st0(16'h0010, 4'h0, 32'h0,        4'hF), 1, 0, 14'h004, 4'h0, 4'hF, 0, 32'h0BAD000C, 0, 32'hCAFE0008);
        tbl[10] = mkv(st1(16'h0040, 4'h0, 32'h00000055, 4'h0), 0, 1, 14'h010, 4'h0, 4'h0, 0, 32'h0BAD000C, 0, 32'hCAFE0008);
        tbl[11] = mkv(st_idle(),                               0, 0, 14'h010, 4'h0, 4'h0, 1, 32'hDEADBE44, 0, 32'hCAFE0008);
        tbl[12] = mkv(st_idle(),                               0, 0, 14'h010, 4'h0, 4'h0, 0, 32'hDEADBE44, 0, 32'hCAFE0008);

        // Reset with both ports requesting: grants must stay low.
        s = st0(16'h0010, 4'h0, 32'h0, 4'hF);
        s.req1 = 1'b1; s.re1 = 4'hF;
        s.rst = 1'b1;
        step(s);
        step(s);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].s);
            chk($sformatf("tbl%0d_g0", i),   32'(dg0),         32'(tbl[i].g0));
            chk($sformatf("tbl%0d_g1", i),   32'(dg1),         32'(tbl[i].g1));
            chk($sformatf("tbl%0d_sa", i),   32'(bus.sram_a),  32'(tbl[i].sa));
            chk($sformatf("tbl%0d_swe", i),  32'(bus.sram_we), 32'(tbl[i].swe));
            chk($sformatf("tbl%0d_sre", i),  32'(bus.sram_re), 32'(tbl[i].sre));
            chk($sformatf("tbl%0d_v0", i),   32'(bus.m0_rvld), 32'(tbl[i].v0));
            chk($sformatf("tbl%0d_d0", i),   bus.m0_rd,        tbl[i].d0);
            chk($sformatf("tbl%0d_v1", i),   32'(bus.m1_rvld), 32'(tbl[i].v1));
            chk($sformatf("tbl%0d_d1", i),   bus.m1_rd,        tbl[i].d1);
        end

        // Sustained contention: port 1 wins every fifth cycle.
        s = st0(16'h0100, 4'h0, 32'h0, 4'h0);
        s.req1 = 1'b1; s.a1 = 16'h0200;
        for (int i = 0; i < 15; i++) begin
            step(s);
            chk($sformatf("cont%0d_g1", i), 32'(dg1), 32'((i % 5) == 4));
            chk($sformatf("cont%0d_g0", i), 32'(dg0), 32'((i % 5) != 4));
        end
        step(st_idle());

        // Reset one cycle after a read accept discards the read.
        step(st0(16'h0010, 4'h0, 32'h0, 4'hF));
        s = st0(16'h0010, 4'h0, 32'h0, 4'hF);
        s.rst = 1'b1;
        step(s);
        chk("rst_sram_re", 32'(bus.sram_re), 32'h0);
        chk("rst_sram_a",  32'(bus.sram_a),  32'h0);
        for (int i = 0; i < 3; i++) begin
            step(st_idle());
            chk($sformatf("rst_rvld0_%0d", i), 32'(bus.m0_rvld), 32'h0);
        end
        step(st0(16'h0010, 4'h0, 32'h0, 4'hF));
        step(st_idle());
        step(st_idle());
        chk("post_rst_rvld", 32'(bus.m0_rvld), 32'h1);
        chk("post_rst_rd",   bus.m0_rd,        32'hDEADBE44);

        // Randomized traffic: requests held until granted, occasional drops and resets.
        pend0 = 1'b0; pend1 = 1'b0;
        p0 = '0; p1 = '0;
        for (int c = 0; c < 600; c++) begin
            if (!pend0) begin
                p0 = '0;
                if ($urandom_range(0, 3) != 0) begin
                    p0 = st0(16'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)),
                             ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                             32'($urandom), 4'($urandom));
                    pend0 = 1'b1;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                p0 = '0; pend0 = 1'b0;
            end
            if (!pend1) begin
                p1 = '0;
                if ($urandom_range(0, 2) != 0) begin
                    p1 = st1(16'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)),
                             ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                             32'($urandom), 4'($urandom));
                    pend1 = 1'b1;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                p1 = '0; pend1 = 1'b0;
            end
            s = '0;
            s.req0 = p0.req0; s.a0 = p0.a0; s.we0 = p0.we0; s.wd0 = p0.wd0; s.re0 = p0.re0;
            s.req1 = p1.req1; s.a1 = p1.a1; s.we1 = p1.we1; s.wd1 = p1.wd1; s.re1 = p1.re1;
            s.rst  = ($urandom_range(0, 99) == 0);
            step(s);
            if (eg0) pend0 = 1'b0;
            if (eg1) pend1 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data SRAM (sram1: 32-bit words, per-byte write/read enables, one-cycle registered access) between two requesters.
- Port 0 is the core LSU. Port 1 is the DMA/debug loader.
- Per-port req/gnt handshake; fixed priority to port 0 with an anti-starvation override for port 1.
- Registers the SRAM command and routes read data back to the requester that issued it.

Parameters:
- AW, 16, byte-address width of each requester port.
- MAX_WAIT, 4, consecutive cycles port 1 may be denied while requesting before it is forced a grant (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- m0_req  in  1  port 0 request.
- m0_a  in  AW  port 0 byte address; bits [1:0] ignored.
- m0_we  in  4  port 0 byte write enables.
- m0_wd  in  32  port 0 write data.
- m0_re  in  4  port 0 byte read enables.
- m0_gnt  out  1  port 0 grant (combinational).
- m0_rd  out  32  port 0 read data.
- m0_rvld  out  1  port 0 read data valid.
- m1_req, m1_a, m1_we, m1_wd, m1_re, m1_gnt, m1_rd, m1_rvld: same as port 0, for port 1.
- sram_a  out  AW-2  word address to SRAM.
- sram_we  out  4  byte write enables to SRAM.
- sram_wd  out  32  write data to SRAM.
- sram_re  out  4  byte read enables to SRAM.
- sram_rd  in  32  SRAM read data, valid the cycle after sram_re is presented.

Behaviour:
- Reset is synchronous and active-high. While rst=1 at a clock edge:
  - sram_a=0, sram_we=0, sram_wd=0, sram_re=0.
  - m0_rvld=0, m1_rvld=0, m0_rd=0, m1_rd=0.
  - wait_cnt=0; read-tracking pipeline cleared.
  - gnt outputs are forced 0 while rst=1.
- Transfer: a request is accepted in a cycle where mX_req=1 and mX_gnt=1. At most one grant per cycle.
- Arbiter has two states:
  - NORMAL: m0_gnt=m0_req; m1_gnt=m1_req & ~m0_req.
  - FORCE1: entered when wait_cnt==MAX_WAIT. Here m1_gnt=m1_req and m0_gnt=0. Returns to NORMAL after one port-1 accept, or when m1_req drops.
- wait_cnt (4 bits):
  - Increments each cycle m1_req=1 and m1 is not granted.
  - Clears on a port-1 accept or when m1_req=0.
  - Saturates at MAX_WAIT.
- Command register: on accept, next edge loads:
  - sram_a = mX_a[AW-1:2]
  - sram_wd = mX_wd
  - sram_we = mX_we
  - sram_re = (mX_we!=0) ? 0 : mX_re (writes mask reads).
- With no accept in a cycle, next edge loads sram_we=0 and sram_re=0; sram_a and sram_wd hold.
- Read return:
  - A 2-stage tracking pipe carries {valid, owner, re}.
  - mX_rvld pulses exactly 2 cycles after the accept edge, only for the owning port, only if masked re!=0.
  - mX_rd = sram_rd with bytes not enabled in re driven 0.
  - mX_rd holds its value until the next rvld for that port.
- Writes produce no response. Write-then-read to the same word on consecutive accepts returns the new data, because the SRAM writes before the next read.
- Throughput: one accept per cycle, fully pipelined, no bubbles.
- req with we=0 and re=0 is accepted as a no-op: no SRAM enables, no rvld.
- Requesters must hold req/a/we/wd/re stable until granted. A req deasserted without a grant is legal and is simply dropped.
- Reset mid-operation: in-flight reads are discarded; no rvld after the reset edge.

Test Plan:
- Port 0 alone: accept write a=0x0010, we=4'hF, wd=0xDEADBEEF, then read a=0x0010, re=4'hF → sram_a=0x004 one cycle after each accept; m0_rvld two cycles after the read accept with m0_rd=0xDEADBEEF; m1_rvld stays 0.
- Byte read: after the previous write, read with re=4'b0100 → m0_rd=0x00AD0000.
- Contention, MAX_WAIT=4: m0_req and m1_req held high continuously → m1 denied 4 cycles, granted on the 5th, m0 granted on the other cycles, repeating; each grant is exclusive.
- Back-to-back mixed: m1 reads word 0x0008 while m0 reads word 0x000C in consecutive cycles → each port's rvld fires for its own data only, in order, with no bubbles.
- Write-masks-read: m0 request with we=4'h1, re=4'hF → sram_re=0 and no m0_rvld.
- Reset mid-read: assert rst one cycle after a read accept → no rvld after reset; all outputs zero; a fresh accept after rst=0 works normally.
